sfp_bank: RTL and testbench
===========================

Name: sfp_bank

Overview:
- Next-generation special-function processor at the bottom of the MAC array.
- Each column holds DEPTH independent accumulators, selected by an address. Accumulation uses a wider, saturating accumulator.
- Results are drained to the output FIFO under back-pressure. ReLU and narrowing saturation are applied on the output path.
- Lets one array pass accumulate several output channels / tiles before writing out.

Parameters:
- COL, 8, number of array columns
- PSUM_BW, 16, signed partial-sum width per column
- ACC_BW, 24, signed accumulator width (ACC_BW >= PSUM_BW)
- OUT_BW, 16, signed output width per column (OUT_BW <= ACC_BW)
- DEPTH, 4, accumulator entries per column (>= 2)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_psum  in  PSUM_BW*COL  packed psums, column k at [(k+1)*PSUM_BW-1 : k*PSUM_BW]
- valid_in  in  COL  per-column psum valid
- acc_addr  in  clog2(DEPTH)  accumulator entry written this cycle
- acc_clear  in  1  load instead of add for this cycle's valid columns
- relu_en  in  1  apply ReLU on drained values
- drain_start  in  1  pulse: begin draining all entries
- ofifo_full  in  1  FIFO cannot accept a write next cycle (almost-full semantics)
- out_accum  out  OUT_BW*COL  drained values, same packing as in_psum
- wr_ofifo  out  COL  per-column FIFO write enable
- o_valid  out  1  OR of wr_ofifo
- busy  out  1  high in DRAIN
- drain_done  out  1  one-cycle pulse after last entry written

Behaviour:
- Reset:
  - state IDLE; all accumulators 0; drain pointer 0.
  - out_accum 0, wr_ofifo 0, o_valid 0, busy 0, drain_done 0.
  - Reset mid-drain aborts immediately; nothing further is written.
- FSM states: IDLE, DRAIN, DONE.
  - IDLE -> DRAIN on drain_start.
  - DRAIN -> DONE when entry DEPTH-1 is issued.
  - DONE -> IDLE unconditionally. drain_done=1 for that one cycle.
- Accumulate (IDLE only), for each column k with valid_in[k]=1:
  - acc[k][acc_addr] <= sat_ACC(acc_clear ? sext(psum_k) : acc[k][acc_addr] + sext(psum_k)).
  - The sum is formed at ACC_BW+1 bits, then clamped to the signed ACC_BW range.
  - Columns with valid_in=0 are unchanged. acc_clear without valid_in has no effect.
  - Visible one cycle later.
- drain_start with valid_in in the same IDLE cycle: the accumulation is applied and is included in the drain.
- drain_start while not IDLE: ignored.
- valid_in in DRAIN/DONE: dropped; accumulators unchanged.
- Drain:
  - Each DRAIN cycle with ofifo_full=0 issues entry ptr; then ptr++.
  - When ofifo_full=1, nothing is issued and ptr holds.
  - Issue at cycle t gives, at cycle t+1: wr_ofifo=all ones, o_valid=1, out_accum[k]=sat_OUT(relu_en && acc<0 ? 0 : acc).
  - In every other cycle wr_ofifo=0; out_accum holds its last value.
  - ptr wraps to 0 on completion.
  - Entries keep their values after draining; a new tile starts with acc_clear.
- sat_OUT clamps to [-(2^(OUT_BW-1)), 2^(OUT_BW-1)-1].
- Exactly DEPTH writes per drain regardless of stalls; stalls may appear on any cycle, including the last entry.

Optional Feature:
- SFP_SAT_FLAG_EN defined:
  - Adds output port sat_flag, COL bits.
  - Bit k is sticky, set when column k saturates in accumulate or on output.
  - Cleared by reset or by drain_done.
- Not defined: no port, no flag logic.

Decomposition:
- Shared package sfp_pkg holds:
  - state enum (IDLE/DRAIN/DONE);
  - signed min/max constant functions for a given width, for sat_ACC and sat_OUT.
- One natural sub-module: sfp_bank_col. It holds a single column's DEPTH-entry storage, the add/saturate logic and the output ReLU/saturate path.
- sfp_bank itself holds the FSM, drain pointer, handshake, and a generate loop over COL.

Test Plan:
- Accumulate, then drain:
  - DEPTH=4, column 0: 3 psums of +100 to addr 2, with acc_clear on the first.
  - drain_start, ofifo_full=0.
  - Expect 4 consecutive wr_ofifo pulses starting 2 cycles after drain_start; entry 2 gives 300, the others 0; drain_done on the cycle after the last pulse.
- ReLU and saturation:
  - ACC_BW=24, OUT_BW=16; accumulate -5 into addr 0 and 40000 into addr 1; relu_en=1.
  - Drained values are 0 and 32767.
- Accumulator saturation:
  - Repeatedly add 32767 into one entry until past 2^23-1.
  - Entry holds 8388607; it does not wrap negative.
- Back-pressure:
  - ofifo_full high for 3 cycles mid-drain.
  - No writes while stalled; total writes = DEPTH, in entry order 0..3; no duplicate or skipped entries.
- Simultaneous events and reset:
  - valid_in together with drain_start is included in the drained data.
  - valid_in during DRAIN is dropped.
  - reset asserted mid-drain clears all outputs the next cycle and leaves the block in IDLE with all entries 0.

Source files
------------

// File: rtl/sfp_pkg.sv
// Shared definitions for the sfp_bank special-function processor:
// drain FSM state encoding and signed range helpers used for clamping.
package sfp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_t;

    // Largest value representable in a w-bit two's-complement number.
    function automatic longint smax(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Smallest value representable in a w-bit two's-complement number.
    function automatic longint smin(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/sfp_bank_col.sv
// One array column: DEPTH saturating accumulators plus the output path
// (optional ReLU, then narrowing saturation to OUT_BW).
// Optional feature macro: SFP_SAT_FLAG_EN adds a per-column saturation event.
module sfp_bank_col
    import sfp_pkg::*;
#(
    parameter int PSUM_BW = 16,
    parameter int ACC_BW  = 24,
    parameter int OUT_BW  = 16,
    parameter int DEPTH   = 4
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [PSUM_BW-1:0]  psum,
    input  logic                       acc_en,
    input  logic                       acc_clear,
    input  logic [$clog2(DEPTH)-1:0]   acc_addr,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    input  logic                       relu_en,
    output logic [OUT_BW-1:0]          out_val
`ifdef SFP_SAT_FLAG_EN
    ,
    output logic                       sat_evt
`endif
);

    localparam logic signed [ACC_BW-1:0] ACC_HI = ACC_BW'(smax(ACC_BW));
    localparam logic signed [ACC_BW-1:0] ACC_LO = ACC_BW'(smin(ACC_BW));
    localparam logic signed [OUT_BW-1:0] OUT_HI = OUT_BW'(smax(OUT_BW));
    localparam logic signed [OUT_BW-1:0] OUT_LO = OUT_BW'(smin(OUT_BW));

    logic signed [ACC_BW-1:0] mem [DEPTH];
    logic signed [ACC_BW:0]   acc_sum;
    logic signed [ACC_BW-1:0] acc_next;
    logic                     acc_ov_hi, acc_ov_lo;
    logic signed [ACC_BW-1:0] rd_val, relu_val;
    logic                     out_ov_hi, out_ov_lo;
    logic [OUT_BW-1:0]        out_next;

    // Add (or load) at one extra bit, then clamp to the accumulator range.
    always_comb begin
        acc_sum   = acc_clear ? (ACC_BW+1)'(psum)
                              : (ACC_BW+1)'(mem[acc_addr]) + (ACC_BW+1)'(psum);
        acc_ov_hi = acc_sum > (ACC_BW+1)'(ACC_HI);
        acc_ov_lo = acc_sum < (ACC_BW+1)'(ACC_LO);
        if (acc_ov_hi)      acc_next = ACC_HI;
        else if (acc_ov_lo) acc_next = ACC_LO;
        else                acc_next = acc_sum[ACC_BW-1:0];
    end

    // Output path: ReLU first, then narrow with saturation.
    always_comb begin
        rd_val    = mem[rd_addr];
        relu_val  = (relu_en && (rd_val < 0)) ? '0 : rd_val;
        out_ov_hi = relu_val > ACC_BW'(OUT_HI);
        out_ov_lo = relu_val < ACC_BW'(OUT_LO);
        if (out_ov_hi)      out_next = OUT_HI;
        else if (out_ov_lo) out_next = OUT_LO;
        else                out_next = relu_val[OUT_BW-1:0];
    end

    // Accumulator storage update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (acc_en) begin
            mem[acc_addr] <= acc_next;
        end
    end

    // Output register: loads on issue, otherwise holds the last drained value.
    always_ff @(posedge clk) begin
        if (reset)      out_val <= '0;
        else if (rd_en) out_val <= out_next;
    end

`ifdef SFP_SAT_FLAG_EN
    // Saturation event seen this cycle on either the accumulate or output path.
    always_comb begin
        sat_evt = (acc_en && (acc_ov_hi || acc_ov_lo)) || (rd_en && (out_ov_hi || out_ov_lo));
    end
`endif

endmodule

// File: rtl/sfp_bank.sv
// sfp_bank: per-column multi-entry saturating accumulators with a
// back-pressured drain to the output FIFO.
// Optional feature macro: SFP_SAT_FLAG_EN adds sticky per-column sat_flag.
module sfp_bank
    import sfp_pkg::*;
#(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ACC_BW  = 24,
    parameter int OUT_BW  = 16,
    parameter int DEPTH   = 4
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PSUM_BW*COL-1:0]    in_psum,
    input  logic [COL-1:0]            valid_in,
    input  logic [$clog2(DEPTH)-1:0]  acc_addr,
    input  logic                      acc_clear,
    input  logic                      relu_en,
    input  logic                      drain_start,
    input  logic                      ofifo_full,
    output logic [OUT_BW*COL-1:0]     out_accum,
    output logic [COL-1:0]            wr_ofifo,
    output logic                      o_valid,
    output logic                      busy,
    output logic                      drain_done
`ifdef SFP_SAT_FLAG_EN
    ,
    output logic [COL-1:0]            sat_flag
`endif
);

    localparam int AW = $clog2(DEPTH);

    state_t        state;
    logic [AW-1:0] ptr;
    logic          issue;
    logic          acc_en;

    // Issue one entry per unstalled DRAIN cycle; accumulate only while idle.
    always_comb begin
        issue  = (state == DRAIN) && !ofifo_full;
        acc_en = (state == IDLE);
    end

    // Drain FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            wr_ofifo   <= '0;
            o_valid    <= 1'b0;
            busy       <= 1'b0;
            drain_done <= 1'b0;
        end else begin
            wr_ofifo   <= {COL{issue}};
            o_valid    <= issue;
            drain_done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (drain_start) begin
                        state <= DRAIN;
                        busy  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        if (ptr == AW'(DEPTH - 1)) begin
                            ptr   <= '0;
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SFP_SAT_FLAG_EN
    logic [COL-1:0] sat_evt;

    // Sticky saturation flags, cleared by reset or the drain_done pulse.
    always_ff @(posedge clk) begin
        if (reset) sat_flag <= '0;
        else       sat_flag <= (drain_done ? '0 : sat_flag) | sat_evt;
    end
`endif

    for (genvar k = 0; k < COL; k++) begin : g_col
        sfp_bank_col #(
            .PSUM_BW (PSUM_BW),
            .ACC_BW  (ACC_BW),
            .OUT_BW  (OUT_BW),
            .DEPTH   (DEPTH)
        ) u_col (
            .clk       (clk),
            .reset     (reset),
            .psum      (in_psum[k*PSUM_BW +: PSUM_BW]),
            .acc_en    (acc_en && valid_in[k]),
            .acc_clear (acc_clear),
            .acc_addr  (acc_addr),
            .rd_en     (issue),
            .rd_addr   (ptr),
            .relu_en   (relu_en),
            .out_val   (out_accum[k*OUT_BW +: OUT_BW])
`ifdef SFP_SAT_FLAG_EN
            ,
            .sat_evt   (sat_evt[k])
`endif
        );
    end

endmodule

// File: tb/tb_sfp_bank.sv
// Self-checking bench for sfp_bank: random and directed stimulus compared
// against a behavioural accumulator/drain model.
module tb_sfp_bank;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int ACC_BW  = 24;
    localparam int OUT_BW  = 16;
    localparam int DEPTH   = 4;
    localparam int AW      = $clog2(DEPTH);
    localparam int MAXC    = 60;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [PSUM_BW*COL-1:0] in_psum;
    logic [COL-1:0]         valid_in;
    logic [AW-1:0]          acc_addr;
    logic                   acc_clear, relu_en, drain_start, ofifo_full;
    logic [OUT_BW*COL-1:0]  out_accum;
    logic [COL-1:0]         wr_ofifo;
    logic                   o_valid, busy, drain_done;

    sfp_bank #(
        .COL(COL), .PSUM_BW(PSUM_BW), .ACC_BW(ACC_BW), .OUT_BW(OUT_BW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .in_psum(in_psum), .valid_in(valid_in),
        .acc_addr(acc_addr), .acc_clear(acc_clear), .relu_en(relu_en),
        .drain_start(drain_start), .ofifo_full(ofifo_full), .out_accum(out_accum),
        .wr_ofifo(wr_ofifo), .o_valid(o_valid), .busy(busy), .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    longint acc_m [COL][DEPTH];
    logic [OUT_BW*COL-1:0] cap_data[$];
    logic [COL-1:0]        cap_wr[$];
    int                    cap_cyc[$];
    int                    exp_cyc[$];
    int                    done_cyc, exp_done;
    logic                  busy0;

    function automatic longint clamp(input longint x, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < COL; k++)
            for (int e = 0; e < DEPTH; e++) acc_m[k][e] = 0;
    endfunction

    function automatic void model_acc(input logic [COL-1:0] v, input int a, input bit c,
                                      input logic [PSUM_BW*COL-1:0] p);
        for (int k = 0; k < COL; k++) begin
            logic signed [PSUM_BW-1:0] s;
            s = p[k*PSUM_BW +: PSUM_BW];
            if (v[k]) acc_m[k][a] = clamp(c ? longint'(s) : acc_m[k][a] + longint'(s), ACC_BW);
        end
    endfunction

    function automatic longint exp_out(input int k, input int e, input bit relu);
        longint x;
        x = acc_m[k][e];
        if (relu && x < 0) x = 0;
        return clamp(x, OUT_BW);
    endfunction

    function automatic longint got_out(input int e, input int k);
        logic [OUT_BW*COL-1:0]    d;
        logic signed [OUT_BW-1:0] g;
        d = cap_data[e];
        g = d[k*OUT_BW +: OUT_BW];
        return longint'(g);
    endfunction

    function automatic logic [PSUM_BW*COL-1:0] rand_psum(input int mag);
        logic [PSUM_BW*COL-1:0] r;
        for (int k = 0; k < COL; k++) begin
            int x;
            x = int'($urandom_range(2 * mag)) - mag;
            r[k*PSUM_BW +: PSUM_BW] = PSUM_BW'(x);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_cycle(input logic [COL-1:0] v, input int a, input bit c,
                             input logic [PSUM_BW*COL-1:0] p);
        valid_in = v; acc_addr = AW'(a); acc_clear = c; in_psum = p;
        tick();
        model_acc(v, a, c, p);
        valid_in = '0; acc_clear = 1'b0;
    endtask

    // Runs one drain from IDLE and records every write; also builds the
    // expected write schedule from the stall pattern.
    task automatic do_drain(input bit relu, input logic [63:0] stall,
                            input logic [COL-1:0] v0, input int a0, input bit c0,
                            input logic [PSUM_BW*COL-1:0] p0, input bit junk);
        int cnt;
        cap_data.delete(); cap_wr.delete(); cap_cyc.delete(); exp_cyc.delete();
        done_cyc = -1; exp_done = -1; cnt = 0;
        for (int n = 1; n < 64 && cnt < DEPTH; n++) begin
            if (!stall[n]) begin
                exp_cyc.push_back(n);
                cnt++;
                if (cnt == DEPTH) exp_done = n + 1;
            end
        end
        relu_en = relu; drain_start = 1'b1;
        valid_in = v0; acc_addr = AW'(a0); acc_clear = c0; in_psum = p0;
        tick();
        model_acc(v0, a0, c0, p0);
        busy0 = busy;
        drain_start = 1'b0; valid_in = '0; acc_clear = 1'b0;
        for (int n = 1; n <= MAXC; n++) begin
            ofifo_full = (n < 64) ? stall[n] : 1'b0;
            if (junk) begin
                valid_in = '1; in_psum = rand_psum(30000); acc_addr = AW'($urandom_range(DEPTH - 1));
            end
            tick();
            if (wr_ofifo !== '0 || o_valid !== 1'b0) begin
                cap_data.push_back(out_accum); cap_wr.push_back(wr_ofifo); cap_cyc.push_back(n);
            end
            if (drain_done === 1'b1) begin
                done_cyc = n;
                break;
            end
        end
        valid_in = '0; ofifo_full = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_psum = '0; valid_in = '0; acc_addr = '0; acc_clear = 1'b0;
        relu_en = 1'b0; drain_start = 1'b0; ofifo_full = 1'b0;
        tick(); tick();
        model_reset();
        n_checks++; if (out_accum !== '0) begin n_fail++; $display("FAIL reset_out got %h need 0", out_accum); end
        n_checks++; if (wr_ofifo !== '0) begin n_fail++; $display("FAIL reset_wr got %b need 0", wr_ofifo); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid got %b need 0", o_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b need 0", busy); end
        n_checks++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b need 0", drain_done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_accumulate_drain();
        logic [PSUM_BW*COL-1:0] p;
        p = '0;
        p[0 +: PSUM_BW] = PSUM_BW'(100);
        acc_cycle(8'h01, 2, 1'b1, p);
        acc_cycle(8'h01, 2, 1'b0, p);
        acc_cycle(8'h01, 2, 1'b0, p);
        do_drain(1'b0, '0, '0, 0, 1'b0, '0, 1'b0);
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL accdrain_busy got %b need 1", busy0); end
        for (int e = 0; e < DEPTH; e++) begin
            n_checks++;
            if (e >= cap_cyc.size() || cap_cyc[e] != e + 1 || cap_wr[e] !== '1) begin
                n_fail++; $display("FAIL accdrain_sched entry %0d got cycle %0d need %0d", e, (e < cap_cyc.size()) ? cap_cyc[e] : -1, e + 1);
            end else begin
                for (int k = 0; k < COL; k++) begin
                    n_checks++;
                    if (got_out(e, k) !== exp_out(k, e, 1'b0)) begin
                        n_fail++; $display("FAIL accdrain_data e%0d c%0d got %0d need %0d", e, k, got_out(e, k), exp_out(k, e, 1'b0));
                    end
                end
            end
        end
        n_checks++; if (cap_data.size() == DEPTH && got_out(2, 0) !== 300) begin n_fail++; $display("FAIL accdrain_300 got %0d need 300", got_out(2, 0)); end
        n_checks++; if (done_cyc != 5) begin n_fail++; $display("FAIL accdrain_done got cycle %0d need 5", done_cyc); end
    endtask

    task automatic test_relu_sat();
        logic [PSUM_BW*COL-1:0] p;
        p = '0; p[0 +: PSUM_BW] = PSUM_BW'(-5);
        acc_cycle(8'h01, 0, 1'b1, p);
        p = '0; p[0 +: PSUM_BW] = PSUM_BW'(20000);
        acc_cycle(8'h01, 1, 1'b1, p);
        acc_cycle(8'h01, 1, 1'b0, p);
        do_drain(1'b1, '0, '0, 0, 1'b0, '0, 1'b0);
        n_checks++;
        if (cap_data.size() != DEPTH) begin
            n_fail++; $display("FAIL relu_count got %0d need %0d", cap_data.size(), DEPTH);
        end else begin
            n_checks++; if (got_out(0, 0) !== 0) begin n_fail++; $display("FAIL relu_neg got %0d need 0", got_out(0, 0)); end
            n_checks++; if (got_out(1, 0) !== 32767) begin n_fail++; $display("FAIL relu_sat got %0d need 32767", got_out(1, 0)); end
            for (int e = 0; e < DEPTH; e++)
                for (int k = 0; k < COL; k++) begin
                    n_checks++;
                    if (got_out(e, k) !== exp_out(k, e, 1'b1)) begin
                        n_fail++; $display("FAIL relu_data e%0d c%0d got %0d need %0d", e, k, got_out(e, k), exp_out(k, e, 1'b1));
                    end
                end
        end
    endtask

    task automatic test_acc_saturation();
        logic [PSUM_BW*COL-1:0] p;
        for (int k = 0; k < COL; k++) p[k*PSUM_BW +: PSUM_BW] = PSUM_BW'(32767);
        acc_cycle('1, 3, 1'b1, p);
        for (int i = 0; i < 260; i++) acc_cycle('1, 3, 1'b0, p);
        // Pulling 2^23 back out of a held-at-max entry lands on -1; a wrapped
        // or unbounded accumulator would land elsewhere.
        for (int k = 0; k < COL; k++) p[k*PSUM_BW +: PSUM_BW] = PSUM_BW'(-32768);
        for (int i = 0; i < 256; i++) acc_cycle('1, 3, 1'b0, p);
        do_drain(1'b0, '0, '0, 0, 1'b0, '0, 1'b0);
        n_checks++;
        if (cap_data.size() != DEPTH) begin
            n_fail++; $display("FAIL accsat_count got %0d need %0d", cap_data.size(), DEPTH);
        end else begin
            for (int k = 0; k < COL; k++) begin
                n_checks++;
                if (got_out(3, k) !== -1) begin
                    n_fail++; $display("FAIL accsat_hold c%0d got %0d need -1", k, got_out(3, k));
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [63:0] stall;
        for (int e = 0; e < DEPTH; e++) acc_cycle('1, e, 1'b1, rand_psum(1000 * (e + 1)));
        stall = '0; stall[2] = 1'b1; stall[3] = 1'b1; stall[4] = 1'b1;
        do_drain(1'b0, stall, '0, 0, 1'b0, '0, 1'b0);
        n_checks++; if (cap_cyc.size() != DEPTH) begin n_fail++; $display("FAIL bp_count got %0d need %0d", cap_cyc.size(), DEPTH); end
        for (int e = 0; e < DEPTH && e < cap_cyc.size(); e++) begin
            n_checks++;
            if (cap_cyc[e] != exp_cyc[e] || cap_wr[e] !== '1) begin
                n_fail++; $display("FAIL bp_sched entry %0d got cycle %0d need %0d", e, cap_cyc[e], exp_cyc[e]);
            end
            for (int k = 0; k < COL; k++) begin
                n_checks++;
                if (got_out(e, k) !== exp_out(k, e, 1'b0)) begin
                    n_fail++; $display("FAIL bp_data e%0d c%0d got %0d need %0d", e, k, got_out(e, k), exp_out(k, e, 1'b0));
                end
            end
        end
        n_checks++; if (done_cyc != exp_done) begin n_fail++; $display("FAIL bp_done got cycle %0d need %0d", done_cyc, exp_done); end
    endtask

    task automatic test_simultaneous();
        // First drain: accumulate alongside drain_start and inject traffic while draining.
        // Second drain: shows the injected traffic never reached the entries.
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) do_drain(1'b0, '0, 8'hA5, 1, 1'b0, rand_psum(5000), 1'b1);
            else           do_drain(1'b0, '0, '0, 0, 1'b0, '0, 1'b0);
            n_checks++;
            if (cap_data.size() != DEPTH) begin
                n_fail++; $display("FAIL simul_count pass %0d got %0d need %0d", pass, cap_data.size(), DEPTH);
            end else begin
                for (int e = 0; e < DEPTH; e++)
                    for (int k = 0; k < COL; k++) begin
                        n_checks++;
                        if (got_out(e, k) !== exp_out(k, e, 1'b0)) begin
                            n_fail++; $display("FAIL simul_data pass %0d e%0d c%0d got %0d need %0d", pass, e, k, got_out(e, k), exp_out(k, e, 1'b0));
                        end
                    end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int e = 0; e < DEPTH; e++) acc_cycle('1, e, 1'b1, rand_psum(20000));
        drain_start = 1'b1; tick(); drain_start = 1'b0;
        tick(); tick();
        reset = 1'b1; tick();
        n_checks++; if (out_accum !== '0) begin n_fail++; $display("FAIL rstmid_out got %h need 0", out_accum); end
        n_checks++; if (wr_ofifo !== '0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr got %b/%b need 0/0", wr_ofifo, o_valid); end
        n_checks++; if (busy !== 1'b0 || drain_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b/%b need 0/0", busy, drain_done); end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (wr_ofifo !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got wr %b busy %b need 0 0", wr_ofifo, busy); end
        end
        do_drain(1'b0, '0, '0, 0, 1'b0, '0, 1'b0);
        n_checks++; if (cap_data.size() != DEPTH) begin n_fail++; $display("FAIL rstmid_count got %0d need %0d", cap_data.size(), DEPTH); end
        for (int e = 0; e < DEPTH && e < cap_data.size(); e++) begin
            n_checks++;
            if (cap_data[e] !== '0 || cap_cyc[e] != e + 1) begin
                n_fail++; $display("FAIL rstmid_zero entry %0d got %h at cycle %0d need 0 at %0d", e, cap_data[e], cap_cyc[e], e + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] stall;
        bit          relu;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 20; i++)
                acc_cycle(COL'($urandom), int'($urandom_range(DEPTH - 1)), ($urandom_range(4) == 0),
                          rand_psum(($urandom_range(1) == 1) ? 32767 : 300));
            stall = '0;
            for (int n = 1; n <= 12; n++) stall[n] = ($urandom_range(9) < 3);
            relu = $urandom_range(1) == 1;
            do_drain(relu, stall, COL'($urandom), int'($urandom_range(DEPTH - 1)), 1'b0, rand_psum(2000), $urandom_range(1) == 1);
            n_checks++; if (cap_cyc.size() != DEPTH) begin n_fail++; $display("FAIL rand_count it %0d got %0d need %0d", it, cap_cyc.size(), DEPTH); end
            for (int e = 0; e < DEPTH && e < cap_cyc.size(); e++) begin
                n_checks++;
                if (cap_cyc[e] != exp_cyc[e] || cap_wr[e] !== '1) begin
                    n_fail++; $display("FAIL rand_sched it %0d entry %0d got cycle %0d need %0d", it, e, cap_cyc[e], exp_cyc[e]);
                end
                for (int k = 0; k < COL; k++) begin
                    n_checks++;
                    if (got_out(e, k) !== exp_out(k, e, relu)) begin
                        n_fail++; $display("FAIL rand_data it %0d e%0d c%0d got %0d need %0d", it, e, k, got_out(e, k), exp_out(k, e, relu));
                    end
                end
            end
            n_checks++; if (done_cyc != exp_done) begin n_fail++; $display("FAIL rand_done it %0d got cycle %0d need %0d", it, done_cyc, exp_done); end
        end
    endtask

    initial begin
        test_reset();
        test_accumulate_drain();
        test_relu_sat();
        test_acc_saturation();
        test_back_pressure();
        test_simultaneous();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
